spi_bitrev_slave: RTL and testbench
===================================

# spi_bitrev_slave

Parametrised SPI mode-0 slave peripheral that receives a DATA_W-bit word on MOSI and returns a transformed word on MISO within the same chip-select frame. It is the successor to the fixed 8-bit bit-reverse SPI test peripheral, and sits behind the SoC SPI master as a loopback/verification target. The SPI pins are oversampled in the system clock domain. The block adds selectable width, selectable transform, abort detection and status pulses.

## Interface
Parameters:
- DATA_W, 8: word width in bits; must be ≥2.
- SYNC_STAGES, 2: synchroniser depth on sck/ss/mosi; must be ≥2.

Ports:
- clock  in  1  system clock; the block has one clock.
- resetn  in  1  reset, asynchronous and active-low.
- sck  in  1  SPI clock, CPOL=0, asynchronous to clock.
- ss  in  1  chip select, active-low.
- mosi  in  1  serial data in, MSB first.
- miso  out  1  serial data out, MSB first.
- op  in  2  transform: 0 reverse, 1 echo, 2 invert, 3 reverse+invert.
- rx_word  out  DATA_W  last completely received word.
- rx_valid  out  1  1-cycle pulse when rx_word updates.
- frame_done  out  1  1-cycle pulse when all DATA_W tx bits have been shifted.
- frame_err  out  1  1-cycle pulse when ss rises before frame_done.

## Operation
- Pin inputs pass through SYNC_STAGES flops. Edge detection compares the last two synchronised samples and produces sck_rise, sck_fall, ss_fall and ss_rise.
- FSM states:
  - IDLE: ss_fall → RECV; clear bit counter; latch op.
  - RECV: on sck_rise, shift mosi into rx_shift and increment cnt. When cnt reaches DATA_W, write rx_word, pulse rx_valid, compute tx_shift = f(op, rx_word) and go to SEND.
  - SEND: on sck_fall, present tx_shift MSB on miso, then shift left. After DATA_W falls, the final bit is held until the next sck_fall, then frame_done pulses → DRAIN.
  - DRAIN: ignores further sck edges; miso=0.
  - Any state except IDLE: ss_rise → IDLE. If the state is RECV or SEND, frame_err pulses.
- Transforms: reverse gives tx[i]=rx[DATA_W-1-i]; echo gives tx=rx; invert gives tx=~rx; op 3 gives ~reverse(rx).
- op is sampled only on ss_fall. Changes to op mid-frame have no effect.
- miso value by condition:
  - Synchronised ss high: 1.
  - RECV or DRAIN: 0.
  - SEND before the first sck_fall: 0.
- An aborted frame leaves rx_word unchanged if it was in RECV. No partial word is ever published.
- If ss_fall and ss_rise would need to be handled in the same cycle, the two-sample edge detector rules this out. If ss_rise and sck_rise are detected in the same cycle, ss_rise wins: no shift happens and the frame is aborted.

## Timing
- Reset values: miso=1, rx_word=0, rx_valid=0, frame_done=0, frame_err=0, state IDLE, counters 0. Reset mid-frame forces all of these immediately, asynchronously.
- Pin-to-detect latency: a pin edge is detected SYNC_STAGES+1 clocks after it occurs.
- miso is registered. It changes one clock after sck_fall detection, i.e. SYNC_STAGES+2 clocks after the pin edge.
- Constraint: each sck high and low phase must be ≥ SYNC_STAGES+3 clocks.
- rx_valid and the tx_shift load occur one clock after the DATA_W-th sck_rise detection.
- Frame: DATA_W receive clocks plus DATA_W transmit clocks. The master samples tx bit k on rising edge DATA_W+1+k.
- Pulses are exactly one clock wide. Back-to-back frames need at least one clock of synchronised ss high.

## Structure
- Package spi_bitrev_pkg holds:
  - the op enum (OP_REV, OP_ECHO, OP_INV, OP_REVINV);
  - the state enum (IDLE, RECV, SEND, DRAIN);
  - a transform function parameterised by width.
- One sub-module, spi_pin_sync: a SYNC_STAGES synchroniser with rise/fall outputs, instantiated for sck and ss. mosi uses a plain synchroniser of the same depth so it stays aligned with sck.

## Test plan
- Reset: hold resetn low with ss high → miso=1, rx_word=0, all pulses 0. Release reset → no pulse appears.
- DATA_W=8, op=0, send 0x01 then 8 more clocks → rx_word=0x01 with rx_valid once; miso shifts 0x80; frame_done once; frame_err never.
- DATA_W=8: op=1 with 0xA5 returns 0xA5; op=2 with 0xA5 returns 0x5A; op=3 with 0x0F returns 0x0F.
- DATA_W=16, op=0, send 0x1234 → returns 0x2C48. Then 4 extra sck clocks → miso=0 with no extra pulses.
- Abort: raise ss after 5 rx bits → frame_err pulses, rx_word keeps its previous value, miso=1. Abort after 3 tx bits → frame_err pulses with no frame_done.
- Back-to-back: frame 1 with op=0 and 0xC0 → 0x03. Switch op to 1 mid-frame 1 → frame 1 is unaffected. Frame 2 with 0x3C → 0x3C.
- Reset mid-SEND: all outputs return to reset values at once. The next frame operates normally.

Source files
------------

// File: rtl/spi_bitrev_pkg.sv
// Shared types and the word transform for the SPI bit-reverse slave.
//   op_e    : transform selector carried on the op pins
//   state_e : frame FSM states
//   xform_word(op, data, width) : applies op to the low 'width' bits of data;
//                                 the bits above 'width' come back as zero
package spi_bitrev_pkg;

    // Widest word the transform helper supports.
    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        OP_REV    = 2'd0,
        OP_ECHO   = 2'd1,
        OP_INV    = 2'd2,
        OP_REVINV = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        SEND  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    function automatic logic [MAX_W-1:0] xform_word(input op_e             op_sel,
                                                    input logic [MAX_W-1:0] data,
                                                    input int unsigned      width);
        logic [MAX_W-1:0] rev_full;
        logic [MAX_W-1:0] rev;
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] res;
        for (int i = 0; i < MAX_W; i++) begin
            rev_full[i] = data[MAX_W-1-i];
        end
        // Reversing the full vector puts the word in the top bits; shift it back down.
        rev  = rev_full >> (MAX_W - width);
        mask = {MAX_W{1'b1}} >> (MAX_W - width);
        unique case (op_sel)
            OP_REV:    res = rev;
            OP_ECHO:   res = data & mask;
            OP_INV:    res = ~data & mask;
            OP_REVINV: res = ~rev & mask;
            default:   res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous pin with edge detection.
//   clock, resetn : system clock, async active-low reset
//   pin           : asynchronous input
//   rise, fall    : single-cycle edge strobes from the last two synchronised samples
module spi_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clock,
    input  logic resetn,
    input  logic pin,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_bitrev_slave.sv
// SPI mode-0 slave: receives a DATA_W-bit word on mosi, then returns a transformed
// copy on miso within the same chip-select frame. Pins are oversampled on clock.
//   clock, resetn : system clock, async active-low reset
//   sck, ss, mosi : SPI pins (asynchronous), ss active-low
//   miso          : registered serial out, MSB first, 1 while idle
//   op            : transform select, captured at frame start
//   rx_word       : last completely received word
//   rx_valid      : 1-cycle pulse when rx_word updates
//   frame_done    : 1-cycle pulse after the final tx bit has been held
//   frame_err     : 1-cycle pulse when ss rises mid receive/transmit
module spi_bitrev_slave #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] rx_word,
    output logic              rx_valid,
    output logic              frame_done,
    output logic              frame_err
);
    import spi_bitrev_pkg::*;

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic sck_rise, sck_fall, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    spi_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .RST_VAL    (1'b0)
    ) u_sck_sync (
        .clock (clock),
        .resetn(resetn),
        .pin   (sck),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    // ss idles high, so its synchroniser resets high to avoid a false frame start.
    spi_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES),
        .RST_VAL    (1'b1)
    ) u_ss_sync (
        .clock (clock),
        .resetn(resetn),
        .pin   (ss),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    // Same depth as the sck path so mosi_s is the sample taken alongside the sck edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        end
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_word_q, rx_word_d;
    op_e               op_q, op_d;
    logic              miso_q, miso_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;
    logic [DATA_W-1:0] new_word;
    logic [DATA_W-1:0] tx_word;

    assign new_word = {rx_shift_q, mosi_s};
    assign tx_word  = DATA_W'(xform_word(op_q, MAX_W'(new_word), DATA_W));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        rx_word_d    = rx_word_q;
        op_d         = op_q;
        miso_d       = miso_q;
        rx_valid_d   = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                miso_d = 1'b1;
                if (ss_fall) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    op_d    = op_e'(op);
                    miso_d  = 1'b0;
                end
            end
            RECV: begin
                // ss_rise is checked first so a coincident sck_rise never shifts.
                if (ss_rise) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    miso_d      = 1'b1;
                end else if (sck_rise) begin
                    rx_shift_d = new_word[DATA_W-2:0];
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        rx_word_d  = new_word;
                        rx_valid_d = 1'b1;
                        tx_shift_d = tx_word;
                        cnt_d      = '0;
                        state_d    = SEND;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            SEND: begin
                if (ss_rise) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    miso_d      = 1'b1;
                end else if (sck_fall) begin
                    // The fall after the last bit only ends the hold period.
                    if (cnt_q == CNT_W'(DATA_W)) begin
                        frame_done_d = 1'b1;
                        miso_d       = 1'b0;
                        cnt_d        = '0;
                        state_d      = DRAIN;
                    end else begin
                        miso_d     = tx_shift_q[DATA_W-1];
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                        cnt_d      = cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                miso_d = 1'b0;
                if (ss_rise) begin
                    state_d = IDLE;
                    miso_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            rx_word_q    <= '0;
            op_q         <= OP_REV;
            miso_q       <= 1'b1;
            rx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            rx_word_q    <= rx_word_d;
            op_q         <= op_d;
            miso_q       <= miso_d;
            rx_valid_q   <= rx_valid_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign miso       = miso_q;
    assign rx_word    = rx_word_q;
    assign rx_valid   = rx_valid_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_bitrev_slave.sv
// Bench for spi_bitrev_slave: an 8-bit and a 16-bit instance, each with its own pins,
// driven by a simple SPI master task and checked against a reference transform.
module tb_spi_bitrev_slave;

    localparam int PH = 8;  // clocks per sck phase

    logic        clock = 1'b0;
    logic        resetn;
    logic [1:0]  sck, ss, mosi, miso, rx_valid, frame_done, frame_err;
    logic [1:0]  op_pin [2];
    logic [7:0]  rx_word8;
    logic [15:0] rx_word16;

    always #5 clock = ~clock;

    spi_bitrev_slave #(.DATA_W(8), .SYNC_STAGES(2)) u_dut8 (
        .clock(clock), .resetn(resetn), .sck(sck[0]), .ss(ss[0]), .mosi(mosi[0]),
        .miso(miso[0]), .op(op_pin[0]), .rx_word(rx_word8), .rx_valid(rx_valid[0]),
        .frame_done(frame_done[0]), .frame_err(frame_err[0])
    );

    spi_bitrev_slave #(.DATA_W(16), .SYNC_STAGES(2)) u_dut16 (
        .clock(clock), .resetn(resetn), .sck(sck[1]), .ss(ss[1]), .mosi(mosi[1]),
        .miso(miso[1]), .op(op_pin[1]), .rx_word(rx_word16), .rx_valid(rx_valid[1]),
        .frame_done(frame_done[1]), .frame_err(frame_err[1])
    );

    int n_checks = 0;
    int n_pass   = 0;
    int vcnt [2] = '{0, 0};
    int dcnt [2] = '{0, 0};
    int ecnt [2] = '{0, 0};
    logic [15:0] exp_rx [2];

    // A pulse wider than one clock is seen on two falling edges and over-counts.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (rx_valid[d])   vcnt[d]++;
            if (frame_done[d]) dcnt[d]++;
            if (frame_err[d])  ecnt[d]++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    function automatic logic [15:0] ref_xform(input logic [1:0] o, input logic [15:0] dat,
                                              input int w);
        int unsigned v, r, full;
        v    = dat;
        r    = 0;
        full = (1 << w) - 1;
        for (int i = 0; i < w; i++) r = r * 2 + ((v >> i) & 1);
        case (o)
            2'd0:    return 16'(r);
            2'd1:    return 16'(v);
            2'd2:    return 16'(full - v);
            default: return 16'(full - r);
        endcase
    endfunction

    function automatic logic [15:0] get_rx(input int d);
        return (d == 0) ? {8'h00, rx_word8} : rx_word16;
    endfunction

    // One master frame of stop_at sck clocks. tx_got holds miso sampled on rising
    // edges w+1.., zero_viol counts ones seen where miso must be 0.
    task automatic run_frame(input int d, input logic [1:0] fop, input logic [15:0] data,
                             input int stop_at, input int op_sw_at, input logic [1:0] op_new,
                             input int rst_at, output logic [15:0] tx_got,
                             output int zero_viol);
        int w;
        w         = (d == 0) ? 8 : 16;
        tx_got    = '0;
        zero_viol = 0;
        @(negedge clock);
        op_pin[d] = fop;
        ss[d]     = 1'b0;
        for (int k = 0; k < stop_at; k++) begin
            if (k == op_sw_at) op_pin[d] = op_new;
            if (k == rst_at) begin
                resetn = 1'b0;
                #1;
                check("rst_mid_miso", 32'(miso[d]), 32'd1);
                check("rst_mid_rx_word", 32'(get_rx(d)), 32'd0);
                check("rst_mid_pulses", 32'({rx_valid, frame_done, frame_err}), 32'd0);
                ss[d]   = 1'b1;
                sck[d]  = 1'b0;
                mosi[d] = 1'b0;
                repeat (3) @(negedge clock);
                resetn = 1'b1;
                repeat (PH) @(negedge clock);
                return;
            end
            mosi[d] = (k < w) ? data[w-1-k] : 1'($urandom);
            repeat (PH) @(negedge clock);
            if (k < w || k >= 2 * w) begin
                if (miso[d]) zero_viol++;
            end else begin
                tx_got[2*w-1-k] = miso[d];
            end
            sck[d] = 1'b1;
            repeat (PH) @(negedge clock);
            sck[d] = 1'b0;
        end
        repeat (PH) @(negedge clock);
        ss[d] = 1'b1;
        repeat (PH) @(negedge clock);
    endtask

    task automatic do_frame(input string name, input int d, input logic [1:0] fop,
                            input logic [15:0] data, input int stop_at, input int op_sw_at,
                            input logic [1:0] op_new, input logic [15:0] exp_tx);
        int w, v0, d0, e0, zv, ntx;
        logic [15:0] got, mask;
        w  = (d == 0) ? 8 : 16;
        v0 = vcnt[d];
        d0 = dcnt[d];
        e0 = ecnt[d];
        run_frame(d, fop, data, stop_at, op_sw_at, op_new, -1, got, zv);
        ntx = stop_at - w;
        if (ntx > w) ntx = w;
        mask = '0;
        for (int j = 0; j < ntx; j++) mask[w-1-j] = 1'b1;
        if (stop_at >= w) exp_rx[d] = data;
        if (ntx > 0) check({name, "/tx"}, 32'(got & mask), 32'(exp_tx & mask));
        check({name, "/miso_zero"}, 32'(zv), 32'd0);
        check({name, "/rx_word"}, 32'(get_rx(d)), 32'(exp_rx[d]));
        check({name, "/rx_valid"}, 32'(vcnt[d] - v0), 32'(stop_at >= w));
        check({name, "/frame_done"}, 32'(dcnt[d] - d0), 32'(stop_at >= 2 * w));
        check({name, "/frame_err"}, 32'(ecnt[d] - e0), 32'(stop_at < 2 * w));
        check({name, "/miso_idle"}, 32'(miso[d]), 32'd1);
    endtask

    typedef struct {
        int          dut;
        logic [1:0]  op;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    initial begin
        vec_t        vecs [6];
        logic [15:0] junk;
        int          zjunk;

        vecs[0] = '{0, 2'd0, 16'h0001, 16'h0080};
        vecs[1] = '{0, 2'd1, 16'h00A5, 16'h00A5};
        vecs[2] = '{0, 2'd2, 16'h00A5, 16'h005A};
        vecs[3] = '{0, 2'd3, 16'h000F, 16'h000F};
        vecs[4] = '{1, 2'd0, 16'h1234, 16'h2C48};
        vecs[5] = '{1, 2'd3, 16'hF00D, 16'h4FF0};

        resetn    = 1'b0;
        sck       = 2'b00;
        ss        = 2'b11;
        mosi      = 2'b00;
        op_pin[0] = 2'd0;
        op_pin[1] = 2'd0;
        exp_rx[0] = '0;
        exp_rx[1] = '0;
        repeat (5) @(negedge clock);
        check("reset_miso8", 32'(miso[0]), 32'd1);
        check("reset_miso16", 32'(miso[1]), 32'd1);
        check("reset_rx8", 32'(rx_word8), 32'd0);
        check("reset_rx16", 32'(rx_word16), 32'd0);
        check("reset_pulses", 32'({rx_valid, frame_done, frame_err}), 32'd0);
        resetn = 1'b1;
        repeat (20) @(negedge clock);
        check("post_reset_no_pulse",
              32'(vcnt[0] + vcnt[1] + dcnt[0] + dcnt[1] + ecnt[0] + ecnt[1]), 32'd0);

        for (int i = 0; i < 6; i++) begin
            do_frame($sformatf("vec%0d", i), vecs[i].dut, vecs[i].op, vecs[i].data,
                     (vecs[i].dut == 0) ? 16 : 32, -1, 2'd0, vecs[i].exp);
        end

        // Four sck clocks past the end of a 16-bit frame: miso stays 0, no extra pulses.
        do_frame("extra16", 1, 2'd0, 16'h1234, 36, -1, 2'd0, 16'h2C48);

        // Aborts during receive and during transmit.
        do_frame("abort_rx5", 0, 2'd0, 16'h005E, 5, -1, 2'd0, 16'h0000);
        do_frame("abort_tx3", 0, 2'd1, 16'h0096, 11, -1, 2'd1, 16'h0096);

        // op changed mid-frame must not affect the running frame.
        do_frame("b2b_1", 0, 2'd0, 16'h00C0, 16, 4, 2'd1, 16'h0003);
        do_frame("b2b_2", 0, 2'd1, 16'h003C, 16, -1, 2'd1, 16'h003C);

        // Reset in the middle of SEND, then a normal frame.
        run_frame(0, 2'd0, 16'h00AB, 16, -1, 2'd0, 11, junk, zjunk);
        exp_rx[0] = '0;
        exp_rx[1] = '0;
        check("rst_mid_miso_after", 32'(miso[0]), 32'd1);
        do_frame("after_reset", 0, 2'd2, 16'h0081, 16, -1, 2'd2, 16'h007E);

        for (int i = 0; i < 24; i++) begin
            int          d, w, stop;
            logic [1:0]  o;
            logic [15:0] dat;
            d   = int'($urandom_range(0, 1));
            w   = (d == 0) ? 8 : 16;
            o   = 2'($urandom);
            dat = 16'($urandom);
            if (d == 0) dat = dat & 16'h00FF;
            stop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * w + 3)) : 2 * w;
            do_frame($sformatf("rand%0d", i), d, o, dat, stop, -1, o, ref_xform(o, dat, w));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
